// File: rtl/fifo_axis_reader_pkg.sv
// Shared constants and helpers for the FIFO-to-AXIS read adapter.
// Covers the FIFO word width and the modulo-3 pointer arithmetic of the output buffer.
package fifo_axis_reader_pkg;

  localparam logic [1:0] OBUF_DEPTH = 2'd3;

  function automatic int fifo_word_width(input int data_width, input int has_last);
    return data_width + has_last;
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == OBUF_DEPTH - 2'd1) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_axis_reader_obuf3.sv
// Three-entry register FIFO used as the stream output buffer.
// dout is a mux of registers only, so there is no path from din to the stream outputs.
module fifo_axis_reader_obuf3
  import fifo_axis_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [0:2];
  logic [W-1:0] mem_d [0:2];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({wr, rd})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a 1-cycle-latency FIFO read port into an AXI4-Stream master.
// Reads are issued on credit (buffered + in-flight < 3), never on tready, to keep tready off the rd_en path.
module fifo_axis_reader
  import fifo_axis_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HAS_LAST   = 0,
  localparam int FW        = fifo_word_width(DATA_WIDTH, HAS_LAST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [FW-1:0]         fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [1:0]            occupancy,
  output logic                  idle
);

  logic          inflight_q, inflight_d;
  logic [1:0]    buf_cnt;
  logic [FW-1:0] head;
  logic [2:0]    credit_used;
  logic          pop;

  always_comb begin
    credit_used = {1'b0, buf_cnt} + {2'b00, inflight_q};
    fifo_rd_en  = ~rst & enable & ~fifo_empty & (credit_used < {1'b0, OBUF_DEPTH});
    inflight_d  = fifo_rd_en;
    pop         = m_axis_tvalid & m_axis_tready;
  end

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= inflight_d;
  end

  // The credit rule guarantees a free slot whenever an in-flight word lands.
  fifo_axis_reader_obuf3 #(.W(FW)) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .wr    (inflight_q),
    .din   (fifo_rd_data),
    .rd    (pop),
    .dout  (head),
    .count (buf_cnt)
  );

  assign m_axis_tvalid = (buf_cnt != 2'd0);
  assign m_axis_tdata  = head[DATA_WIDTH-1:0];
  assign occupancy     = buf_cnt + {1'b0, inflight_q};
  assign idle          = (occupancy == 2'd0) & fifo_empty;

  generate
    if (HAS_LAST != 0) begin : g_last
      assign m_axis_tlast = head[FW-1];
    end else begin : g_no_last
      assign m_axis_tlast = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader (HAS_LAST=1) behind a behavioural 16-deep FIFO with 1-cycle read latency.
// Written words go into an expected queue; every handshake beat must match its head in order.
module tb_fifo_axis_reader;

  logic       clk = 1'b0;
  logic       rst, fifo_rst, enable;
  logic       fifo_rd_en, fifo_empty;
  logic [8:0] fifo_rd_data;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [7:0] m_axis_tdata;
  logic [1:0] occupancy;
  logic       idle;

  logic       wr_en, wr_req;
  logic [8:0] wr_data, wr_word;
  logic [8:0] mem [16];
  logic [4:0] wp, rp;

  logic [8:0] exp_q [$];
  logic [8:0] held, first_word, last_word, w;
  logic       stall_prev;
  int compared, mismatched;
  int ncyc, rd_cnt, beats, pushed, first_rd, first_tv, first_beat, last_beat;

  always #5 clk = ~clk;

  fifo_axis_reader #(.DATA_WIDTH(8), .HAS_LAST(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .occupancy     (occupancy),
    .idle          (idle)
  );

  // Behavioural simple_fifo: data appears on fifo_rd_data the cycle after rd_en.
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (fifo_rst) begin
      wp <= '0;
      rp <= '0;
      fifo_rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wp[3:0]] <= wr_data;
        wp <= wp + 5'd1;
      end
      if (fifo_rd_en && (wp != rp)) begin
        fifo_rd_data <= mem[rp[3:0]];
        rp <= rp + 5'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: writes applied at negedge, outputs checked at negedge+1, returns just after posedge.
  task automatic cyc();
    @(negedge clk);
    wr_en = 1'b0;
    if (fifo_rst) begin
      exp_q.delete();
    end else if (wr_req && (wp - rp) != 5'd16) begin
      wr_en   = 1'b1;
      wr_data = wr_word;
      exp_q.push_back(wr_word);
      pushed++;
    end
    wr_req = 1'b0;
    #1;
    ncyc++;
    if (fifo_rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = ncyc;
    end
    if (m_axis_tvalid && first_tv < 0) first_tv = ncyc;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", m_axis_tvalid, 1);
        chk("hold_data", {m_axis_tlast, m_axis_tdata}, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("beat_word", {m_axis_tlast, m_axis_tdata}, w);
        end
        if (beats == 0) first_word = {m_axis_tlast, m_axis_tdata};
        last_word = {m_axis_tlast, m_axis_tdata};
        if (first_beat < 0) first_beat = ncyc;
        last_beat = ncyc;
        beats++;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = {m_axis_tlast, m_axis_tdata};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (n < maxc && !(exp_q.size() == 0 && !m_axis_tvalid && fifo_empty && occupancy == 2'd0)) begin
      cyc();
      n++;
    end
    chk("drain_done", n < maxc, 1);
  endtask

  task automatic clear_stats();
    rd_cnt = 0; beats = 0; pushed = 0;
    first_rd = -1; first_tv = -1; first_beat = -1; last_beat = -1;
  endtask

  task automatic write_word(input logic [8:0] v);
    wr_req  = 1'b1;
    wr_word = v;
    cyc();
  endtask

  initial begin
    compared = 0; mismatched = 0; ncyc = 0;
    wr_en = 0; wr_req = 0; wr_data = '0; wr_word = '0;
    stall_prev = 0; held = '0; first_word = '0; last_word = '0;
    clear_stats();
    rst = 1; fifo_rst = 1; enable = 1; m_axis_tready = 0;

    // Reset state, then reset held while the FIFO holds data
    cyc(); cyc();
    chk("rst_valid", m_axis_tvalid, 0);
    chk("rst_data", {m_axis_tlast, m_axis_tdata}, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_idle_empty", idle, 1);
    fifo_rst = 0;
    write_word(9'h0AA);
    write_word(9'h133);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_hold_rd_en", fifo_rd_en, 0);
      chk("rst_hold_valid", m_axis_tvalid, 0);
      chk("rst_hold_occ", occupancy, 0);
      chk("rst_hold_idle", idle, 0);
    end
    rst = 0; m_axis_tready = 1;
    drain(30);

    // Streaming 16 words at full rate
    clear_stats();
    for (int i = 0; i < 16; i++) write_word(9'(i));
    drain(40);
    chk("stream_beats", beats, 16);
    chk("stream_rd_cnt", rd_cnt, 16);
    chk("stream_latency", first_tv - first_rd, 2);
    chk("stream_no_gaps", last_beat - first_beat, 15);

    // Back-pressure: only three words may leave the FIFO
    enable = 0; m_axis_tready = 0;
    for (int i = 0; i < 8; i++) write_word(9'(i));
    clear_stats();
    enable = 1;
    for (int i = 0; i < 10; i++) cyc();
    chk("bp_rd_cnt", rd_cnt, 3);
    chk("bp_occ", occupancy, 3);
    chk("bp_valid", m_axis_tvalid, 1);
    chk("bp_data", {m_axis_tlast, m_axis_tdata}, 9'h000);
    m_axis_tready = 1;
    drain(40);
    chk("bp_beats", beats, 8);
    chk("bp_last", last_word, 9'h007);

    // Random writes and random tready
    clear_stats();
    for (int c = 0; c < 20000; c++) begin
      if (pushed == 1000 && exp_q.size() == 0) break;
      if (pushed < 1000 && ($urandom % 2) == 1) begin
        wr_req  = 1'b1;
        wr_word = 9'($urandom % 512);
      end
      m_axis_tready = 1'($urandom % 2);
      cyc();
    end
    m_axis_tready = 1;
    drain(50);
    chk("rand_pushed", pushed, 1000);
    chk("rand_beats", beats, 1000);

    // tlast carried in the word MSB
    clear_stats();
    write_word(9'h011);
    write_word(9'h1A5);
    drain(20);
    chk("tlast_first", first_word, 9'h011);
    chk("tlast_second", last_word, 9'h1A5);

    // enable dropped mid-burst: in-flight and buffered words still delivered
    enable = 0;
    for (int i = 0; i < 10; i++) write_word(9'h020 + 9'(i));
    clear_stats();
    enable = 1;
    for (int i = 0; i < 3; i++) cyc();
    enable = 0;
    for (int i = 0; i < 10; i++) cyc();
    chk("en0_rd_cnt", rd_cnt, 3);
    chk("en0_beats", beats, 3);
    chk("en0_valid", m_axis_tvalid, 0);
    chk("en0_occ", occupancy, 0);
    chk("en0_idle", idle, 0);
    enable = 1;
    drain(40);
    chk("en0_total_beats", beats, 10);
    chk("en0_last", last_word, 9'h029);

    // Reset mid-burst with a full buffer
    enable = 0; m_axis_tready = 0;
    for (int i = 0; i < 8; i++) write_word(9'h040 + 9'(i));
    enable = 1;
    for (int i = 0; i < 4; i++) cyc();
    chk("pre_rst_occ", occupancy, 3);
    rst = 1; fifo_rst = 1;
    cyc();
    chk("mid_rst_valid", m_axis_tvalid, 0);
    chk("mid_rst_occ", occupancy, 0);
    rst = 0; fifo_rst = 0; m_axis_tready = 1;
    clear_stats();
    write_word(9'h055);
    drain(20);
    chk("post_rst_beats", beats, 1);
    chk("post_rst_first", first_word, 9'h055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
